// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: widths, size encodings,
// lane masks, FSM state type and the alignment check.
package load_store_unit_pkg;

   localparam int unsigned XLEN = 32;

   // req_size encodings
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   // Byte-lane masks for an access at offset 0; shifted by addr[1:0]
   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } lsu_state_e;

   // Illegal size, or natural alignment violated for half/word
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SIZE_B:  mis = 1'b0;
         SIZE_H:  mis = off[0];
         SIZE_W:  mis = (off != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Sign/zero extension of a narrow load value to the full register width.
module load_store_unit_extend #(
   parameter int unsigned InWidth  = 8,
   parameter int unsigned OutWidth = 32
) (
   input  logic [InWidth-1:0]  data_i,
   input  logic                uext_i,
   output logic [OutWidth-1:0] data_o
);

   logic fill;

   // Replicate the sign bit unless zero-extension is requested
   always_comb begin
      fill   = data_i[InWidth-1] & ~uext_i;
      data_o = {{(OutWidth - InWidth){fill}}, data_i};
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, maps byte/half/word accesses onto
// a word-wide memory port, formats load data and returns a one-cycle response.
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [1:0]      req_size_i,
   input  logic            req_uext_i,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic [XLEN-1:0] req_wdata_i,
   output logic            rsp_valid_o,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_misaligned_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [3:0]      mem_wmask_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_ack_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   lsu_state_e      state_q;
   logic            req_ready_q;
   logic            rsp_valid_q;
   logic [XLEN-1:0] rsp_rdata_q;
   logic            rsp_mis_q;
   logic            mem_req_q;
   logic            mem_we_q;
   logic [XLEN-1:0] mem_addr_q;
   logic [3:0]      mem_wmask_q;
   logic [XLEN-1:0] mem_wdata_q;
   logic [1:0]      size_q;
   logic            uext_q;
   logic [1:0]      off_q;

   logic            mis_d;
   logic [3:0]      wmask_d;
   logic [XLEN-1:0] wdata_d;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] byte_ext;
   logic [XLEN-1:0] half_ext;
   logic [XLEN-1:0] load_data;

   // Decode the incoming request: alignment, lane mask and replicated store data
   always_comb begin
      mis_d = is_misaligned(req_size_i, req_addr_i[1:0]);
      case (req_size_i)
         SIZE_B: begin
            wmask_d = MASK_B << req_addr_i[1:0];
            wdata_d = {4{req_wdata_i[7:0]}};
         end
         SIZE_H: begin
            wmask_d = MASK_H << req_addr_i[1:0];
            wdata_d = {2{req_wdata_i[15:0]}};
         end
         default: begin
            wmask_d = MASK_W;
            wdata_d = req_wdata_i;
         end
      endcase
   end

   // Bring the addressed byte/half down to bit 0
   always_comb begin
      shifted = mem_rdata_i >> {off_q, 3'b000};
   end

   load_store_unit_extend #(
      .InWidth  (8),
      .OutWidth (XLEN)
   ) u_ext_byte (
      .data_i (shifted[7:0]),
      .uext_i (uext_q),
      .data_o (byte_ext)
   );

   load_store_unit_extend #(
      .InWidth  (16),
      .OutWidth (XLEN)
   ) u_ext_half (
      .data_i (shifted[15:0]),
      .uext_i (uext_q),
      .data_o (half_ext)
   );

   // Pick the extended result by captured size; words pass through
   always_comb begin
      case (size_q)
         SIZE_B:  load_data = byte_ext;
         SIZE_H:  load_data = half_ext;
         default: load_data = shifted;
      endcase
   end

   // Control FSM with registered outputs; reset abandons any pending access
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_mis_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wmask_q <= '0;
         mem_wdata_q <= '0;
         size_q      <= SIZE_B;
         uext_q      <= 1'b0;
         off_q       <= 2'b00;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  req_ready_q <= 1'b0;
                  size_q      <= req_size_i;
                  uext_q      <= req_uext_i;
                  off_q       <= req_addr_i[1:0];
                  if (mis_d) begin
                     // Rejected without touching memory
                     rsp_valid_q <= 1'b1;
                     rsp_mis_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                     state_q     <= StResp;
                  end else begin
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= req_we_i;
                     mem_addr_q  <= {req_addr_i[XLEN-1:2], 2'b00};
                     mem_wmask_q <= req_we_i ? wmask_d : 4'b0000;
                     mem_wdata_q <= wdata_d;
                     state_q     <= StAccess;
                  end
               end
            end
            StAccess: begin
               if (mem_ack_i) begin
                  mem_req_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_mis_q   <= 1'b0;
                  rsp_rdata_q <= mem_we_q ? '0 : load_data;
                  state_q     <= StResp;
               end
            end
            StResp: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready_o      = req_ready_q;
   assign rsp_valid_o      = rsp_valid_q;
   assign rsp_rdata_o      = rsp_rdata_q;
   assign rsp_misaligned_o = rsp_mis_q;
   assign mem_req_o        = mem_req_q;
   assign mem_we_o         = mem_we_q;
   assign mem_addr_o       = mem_addr_q;
   assign mem_wmask_o      = mem_wmask_q;
   assign mem_wdata_o      = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_uext;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_misaligned;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_we_i         (req_we),
      .req_size_i       (req_size),
      .req_uext_i       (req_uext),
      .req_addr_i       (req_addr),
      .req_wdata_i      (req_wdata),
      .rsp_valid_o      (rsp_valid),
      .rsp_rdata_o      (rsp_rdata),
      .rsp_misaligned_o (rsp_misaligned),
      .mem_req_o        (mem_req),
      .mem_we_o         (mem_we),
      .mem_addr_o       (mem_addr),
      .mem_wmask_o      (mem_wmask),
      .mem_wdata_o      (mem_wdata),
      .mem_ack_i        (mem_ack),
      .mem_rdata_i      (mem_rdata)
   );

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [1:0] size, input logic uext,
                            input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_uext  = uext;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   task automatic test_reset();
      checks++; if (req_ready !== 1'b1) begin errors++;
         $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0 || rsp_misaligned !== 1'b0 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_rsp: got v=%b m=%b d=%h want 0/0/0",
                            rsp_valid, rsp_misaligned, rsp_rdata); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
                    mem_wmask !== 4'h0 || mem_wdata !== 32'h0) begin
         errors++; $display("FAIL reset_mem: got req=%b we=%b a=%h m=%h d=%h want all 0",
                            mem_req, mem_we, mem_addr, mem_wmask, mem_wdata); end
   endtask

   // lb at 0x103, ack at k=1
   task automatic test_lb();
      drive_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
      step();                                    // T+1
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 ||
                    mem_wmask !== 4'b0000) begin
         errors++; $display("FAIL lb_mem: got req=%b we=%b a=%h m=%b want 1/0/100/0000",
                            mem_req, mem_we, mem_addr, mem_wmask); end
      checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++;
         $display("FAIL lb_t1_ctrl: got ready=%b rsp=%b want 0/0", req_ready, rsp_valid); end
      mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
      step();                                    // T+2
      mem_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_FF80 || rsp_misaligned !== 1'b0)
      begin errors++; $display("FAIL lb_rsp: got v=%b d=%h m=%b want 1/ffffff80/0",
                               rsp_valid, rsp_rdata, rsp_misaligned); end
      checks++; if (mem_req !== 1'b0 || req_ready !== 1'b0) begin errors++;
         $display("FAIL lb_t2_ctrl: got req=%b ready=%b want 0/0", mem_req, req_ready); end
      step();                                    // T+3
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'hFFFF_FF80)
      begin errors++; $display("FAIL lb_t3: got v=%b ready=%b d=%h want 0/1/ffffff80",
                               rsp_valid, req_ready, rsp_rdata); end
   endtask

   // lhu at 0x102, ack at k=3
   task automatic test_lhu_wait();
      drive_req(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
      step();
      req_valid = 1'b0;
      mem_rdata = 32'hBEEF_0000;
      for (int k = 1; k <= 3; k++) begin
         checks++; if (mem_req !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL lhu_wait_k%0d: got req=%b ready=%b rsp=%b want 1/0/0",
                               k, mem_req, req_ready, rsp_valid); end
         if (k == 3) mem_ack = 1'b1;
         step();
      end
      mem_ack = 1'b0;                            // T+4
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_BEEF || mem_req !== 1'b0 ||
                    req_ready !== 1'b0) begin
         errors++; $display("FAIL lhu_rsp: got v=%b d=%h req=%b ready=%b want 1/0000beef/0/0",
                            rsp_valid, rsp_rdata, mem_req, req_ready); end
      step();
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
         $display("FAIL lhu_idle: got ready=%b rsp=%b want 1/0", req_ready, rsp_valid); end
   endtask

   // sb 0xAB at 0x201
   task automatic test_sb();
      drive_req(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h1234_56AB);
      step();
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
                    mem_wmask !== 4'b0010 || mem_wdata !== 32'hABAB_ABAB) begin
         errors++; $display("FAIL sb_mem: got req=%b we=%b a=%h m=%b d=%h want 1/1/200/0010/abababab",
                            mem_req, mem_we, mem_addr, mem_wmask, mem_wdata); end
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      step();
      mem_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_misaligned !== 1'b0) begin
         errors++; $display("FAIL sb_rsp: got v=%b d=%h m=%b want 1/0/0",
                            rsp_valid, rsp_rdata, rsp_misaligned); end
      step();
   endtask

   // lw 0x302, sh 0x101, size=11 at 0x300: all rejected without mem_req
   task automatic test_misaligned();
      logic        we_v   [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  size_v [3] = '{2'b10, 2'b01, 2'b11};
      logic [31:0] addr_v [3] = '{32'h302, 32'h101, 32'h300};
      for (int i = 0; i < 3; i++) begin
         drive_req(we_v[i], size_v[i], 1'b0, addr_v[i], 32'hFFFF_FFFF);
         step();
         req_valid = 1'b0;
         checks++; if (rsp_valid !== 1'b1 || rsp_misaligned !== 1'b1 || rsp_rdata !== 32'h0 ||
                       mem_req !== 1'b0) begin
            errors++; $display("FAIL mis_%0d_rsp: got v=%b m=%b d=%h req=%b want 1/1/0/0",
                               i, rsp_valid, rsp_misaligned, rsp_rdata, mem_req); end
         step();
         checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL mis_%0d_idle: got v=%b ready=%b req=%b want 0/1/0",
                               i, rsp_valid, req_ready, mem_req); end
      end
   endtask

   // Two requests with req_valid held: second accepted in the cycle after RESP
   task automatic test_back_to_back();
      drive_req(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0);
      step();                                    // T+1: A in ACCESS
      drive_req(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h0000_8000;
      step();                                    // T+2: A response
      mem_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0080) begin errors++;
         $display("FAIL b2b_a_rsp: got v=%b d=%h want 1/00000080", rsp_valid, rsp_rdata); end
      step();                                    // T+3: IDLE, B accepted at end
      checks++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin errors++;
         $display("FAIL b2b_idle: got ready=%b req=%b want 1/0", req_ready, mem_req); end
      step();                                    // B in ACCESS
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++;
         $display("FAIL b2b_b_mem: got req=%b a=%h want 1/0", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h8001_0000;
      step();
      mem_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_8001) begin errors++;
         $display("FAIL b2b_b_rsp: got v=%b d=%h want 1/ffff8001", rsp_valid, rsp_rdata); end
      step();
   endtask

   // Reset in ACCESS, late ack ignored, then a normal lw
   task automatic test_reset_mid_access();
      drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
      step();
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1) begin errors++;
         $display("FAIL rst_pre: got req=%b want 1", mem_req); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rst_async: got req=%b v=%b ready=%b want 0/0/1",
                            mem_req, rsp_valid, req_ready); end
      step();
      #2 rst_n = 1'b1;
      step();
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      step();
      mem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_late_ack_%0d: got v=%b req=%b ready=%b want 0/0/1",
                               i, rsp_valid, mem_req, req_ready); end
         step();
      end
      drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
      step();
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_wmask !== 4'b0000) begin
         errors++; $display("FAIL rst_lw_mem: got req=%b a=%h m=%b want 1/400/0000",
                            mem_req, mem_addr, mem_wmask); end
      step();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_misaligned !== 1'b0)
      begin errors++; $display("FAIL rst_lw_rsp: got v=%b d=%h m=%b want 1/deadbeef/0",
                               rsp_valid, rsp_rdata, rsp_misaligned); end
      step();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_uext = 1'b0;
      req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      #12;
      test_reset();
      rst_n = 1'b1;
      step();
      test_lb();
      test_lhu_wait();
      test_sb();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's memory stage and the word-wide data memory port. Accepts one load or store request at a time and maps byte/halfword/word accesses onto 32-bit words with byte-lane write masks. Rotates and sign/zero-extends load data, then returns a single-cycle response. Flags misaligned or illegal-size accesses without touching memory.

## Interface
- XLEN, 32, data and address width; only 32 is supported.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_uext  in  1  zero-extend load result (funct3[2])
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_misaligned  out  1  valid with rsp_valid; access rejected
- mem_req  out  1  memory access request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  XLEN  word address, {req_addr[31:2], 2'b00}
- mem_wmask  out  4  byte-lane write enable
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ack  in  1  memory completed access; mem_rdata valid this cycle for reads
- mem_rdata  in  XLEN  memory read word

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, capture we/size/uext/addr/wdata.
  - Misaligned captures go to RESP with error flag set; mem_req is never raised.
  - All other captures go to ACCESS.
- Misaligned means any of: size=11; half with addr[0]=1; word with addr[1:0]≠00.
- ACCESS: mem_req=1, with mem_we/mem_addr/mem_wmask/mem_wdata stable from the captured request.
  - On mem_ack, register the formatted load data (0 for stores) and go to RESP.
  - No ack means stay in ACCESS indefinitely.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. req_ready=0 in ACCESS and RESP.
- Write mask: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Mask is 0000 on loads.
- Write data: byte replicated ×4; half replicated ×2; word as-is.
- Load format:
  - Shift mem_rdata right by 8·addr[1:0].
  - Byte: bits [7:0], extended to 32. Half: bits [15:0], extended to 32. Word: unchanged.
  - Extension is sign-extension unless uext=1, which zero-extends. uext is ignored for word loads.
- rst_n low at any time, including mid-access: immediately enter IDLE and drop mem_req and rsp_valid. The pending access is abandoned. A late mem_ack in IDLE is ignored.

## Timing
- Reset values:
  - req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_misaligned=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wmask=0, mem_wdata=0.
- Request accepted at edge T (req_valid & req_ready).
- mem_req rises in cycle T+1.
- If mem_ack arrives in cycle T+k (k≥1), rsp_valid is high in cycle T+k+1. Minimum latency is 2 cycles, accept to response.
- Misaligned request: rsp_valid in cycle T+1 with rsp_misaligned=1.
- Throughput: at most one request per 3 cycles (IDLE→ACCESS→RESP→IDLE). Back-to-back acceptance is possible on the cycle after RESP.
- rsp_rdata and rsp_misaligned are registered and hold until the next response. Meaningful only while rsp_valid=1.
- mem_ack in the same cycle mem_req first rises is legal (k=1).

## Structure
- Shared package holds:
  - size encoding constants: SIZE_B, SIZE_H, SIZE_W.
  - FSM state typedef: IDLE/ACCESS/RESP.
  - lane-mask helper constants.
- Sub-module: two instances of the existing `extend` block.
  - 8→32 for bytes and 16→32 for halves, both driven by captured uext.
  - Word result selected by a mux after extension.

## Test plan
- lb at addr 0x103, mem_rdata 0x80FF_1234, ack at k=1 -> rsp_rdata 0xFFFF_FF80 in cycle T+2, mem_addr 0x100, mem_wmask 0000.
- lhu at addr 0x102, mem_rdata 0xBEEF_0000, ack at k=3 -> rsp_rdata 0x0000_BEEF; mem_req high exactly cycles T+1..T+3; req_ready low until RESP ends.
- sb 0xAB at addr 0x201 -> mem_we=1, mem_wmask 0010, mem_wdata 0xABAB_ABAB; rsp_valid with rsp_rdata 0, misaligned 0.
- lw at 0x302 and sh at 0x101 -> no mem_req; rsp_valid at T+1 with rsp_misaligned=1. Also size=11 at 0x300 -> same error response.
- rst_n pulled low in ACCESS before ack, then mem_ack pulses after release -> mem_req drops asynchronously, no rsp_valid, req_ready=1; next lw at 0x400 completes normally.
